booth_mult_core: RTL and testbench

//  Sequential radix-2 Booth signed multiplier of the MDR system. Sits directly upstream of the

---
 rtl/booth_mult_core.sv | 95 +++++++++
 tb/tb_booth_mult_core.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/booth_mult_core.sv
// rtl/booth_mult_core.sv - sequential radix-2 Booth signed multiplier, one step per clock
module booth_mult_core #(
  parameter int DW  = 16,
  parameter int DW2 = 2*DW,
  parameter int CW  = $clog2(DW+1)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           i_start,
  input  logic [DW-1:0]  i_multiplicand,
  input  logic [DW-1:0]  i_multiplier,
  output logic           o_busy,
  output logic           o_flag,
  output logic [DW2:0]   o_data
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  // A and M carry a guard bit so A-M cannot overflow for M = -2^(DW-1)
  logic [DW:0]   a;
  logic [DW:0]   m;
  logic [DW:0]   a_sum;
  logic [DW-1:0] q;
  logic          q_1;
  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_start) state_next = RUN;
      RUN:     if (count == CW'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    a_sum = a;
    case ({q[0], q_1})
      2'b01:   a_sum = a + m;
      2'b10:   a_sum = a - m;
      default: a_sum = a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a     <= '0;
      m     <= '0;
      q     <= '0;
      q_1   <= 1'b0;
      count <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_start) begin
            a     <= '0;
            m     <= {i_multiplicand[DW-1], i_multiplicand};
            q     <= i_multiplier;
            q_1   <= 1'b0;
            count <= CW'(DW);
          end
        end
        RUN: begin
          // arithmetic shift right of {A,Q,q_1} after the add/subtract
          a     <= {a_sum[DW], a_sum[DW:1]};
          q     <= {a_sum[0], q[DW-1:1]};
          q_1   <= q[0];
          count <= count - CW'(1);
        end
        default: begin
        end
      endcase
    end
  end

  assign o_busy = (state != IDLE);
  assign o_flag = (state == DONE);
  assign o_data = {a[DW-1:0], q, q_1};

endmodule

// File: tb/tb_booth_mult_core.sv
// tb/tb_booth_mult_core.sv - directed and random self-checking bench for booth_mult_core
module tb_booth_mult_core;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_start;
  logic [DW-1:0] i_multiplicand;
  logic [DW-1:0] i_multiplier;
  logic          o_busy;
  logic          o_flag;
  logic [2*DW:0] o_data;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clk = ~clk;

  booth_mult_core #(.DW(DW)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_start        (i_start),
    .i_multiplicand (i_multiplicand),
    .i_multiplier   (i_multiplier),
    .o_busy         (o_busy),
    .o_flag         (o_flag),
    .o_data         (o_data)
  );

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] prod(input logic signed [15:0] m, input logic signed [15:0] q);
    int p;
    p = int'(m) * int'(q);
    return 32'(p);
  endfunction

  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp);
    int edges;
    i_multiplicand = m;
    i_multiplier   = q;
    i_start        = 1'b1;
    tick();
    i_start        = 1'b0;
    i_multiplicand = ~m;
    i_multiplier   = ~q;
    edges = 0;
    while (!o_flag && edges < 40) begin
      tick();
      edges++;
    end
    if (o_flag) begin
      check_eq({tag, "_lat"}, 33'(edges), 33'(DW));
      check_eq({tag, "_data"}, {1'b0, o_data[32:1]}, {1'b0, exp});
    end else begin
      check_eq({tag, "_timeout"}, 33'(0), 33'(1));
    end
    tick();
    check_eq({tag, "_flag_off"}, {31'd0, o_flag, o_busy}, 33'd0);
    check_eq({tag, "_hold"}, {1'b0, o_data[32:1]}, {1'b0, exp});
  endtask

  logic [15:0] ops_m [0:53];
  logic [15:0] ops_q [0:53];

  initial begin
    logic [15:0] rm, rq;
    bit          seen;
    rst = 1'b1;
    i_start = 1'b0;
    i_multiplicand = '0;
    i_multiplier = '0;
    repeat (3) tick();
    check_eq("reset_state", {o_data[30:0], o_busy, o_flag}, 33'd0);
    check_eq("reset_data_hi", {31'd0, o_data[32:31]}, 33'd0);
    rst = 1'b0;
    tick();

    run_op("t1_3x5",   16'd3,      16'd5,      32'h0000000F);
    run_op("t2_m7x6",  16'hFFF9,   16'd6,      32'hFFFFFFD6);
    run_op("t2_6xm7",  16'd6,      16'hFFF9,   32'hFFFFFFD6);
    run_op("t2_0xm1",  16'd0,      16'hFFFF,   32'h00000000);
    run_op("t3_minmin",16'h8000,   16'h8000,   32'h40000000);
    run_op("t3_maxmin",16'h7FFF,   16'h8000,   32'hC0008000);
    run_op("t3_m1m1",  16'hFFFF,   16'hFFFF,   32'h00000001);

    // start held high with operands changing every cycle
    i_start = 1'b1;
    for (int c = 0; c < 54; c++) begin
      ops_m[c] = 16'($urandom);
      ops_q[c] = 16'($urandom);
      i_multiplicand = ops_m[c];
      i_multiplier   = ops_q[c];
      tick();
      if (c % 18 == 16) begin
        check_eq("t4_flag", {32'd0, o_flag}, 33'd1);
        check_eq("t4_data", {1'b0, o_data[32:1]}, {1'b0, prod(ops_m[c-16], ops_q[c-16])});
      end else begin
        check_eq("t4_noflag", {32'd0, o_flag}, 33'd0);
      end
    end
    i_start = 1'b0;

    // reset in the 8th RUN cycle aborts the operation
    i_multiplicand = 16'd100;
    i_multiplier   = 16'd77;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    repeat (7) tick();
    check_eq("t5_busy_before", {32'd0, o_busy}, 33'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("t5_after_rst", {o_data[30:0], o_busy, o_flag}, 33'd0);
    check_eq("t5_after_rst_hi", {31'd0, o_data[32:31]}, 33'd0);
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (o_flag) seen = 1'b1;
    end
    check_eq("t5_no_flag", {32'd0, seen}, 33'd0);
    run_op("t5_2x2", 16'd2, 16'd2, 32'h00000004);

    for (int k = 0; k < 1000; k++) begin
      rm = 16'($urandom);
      rq = 16'($urandom);
      run_op("t6_rand", rm, rq, prod(rm, rq));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
